// File: rtl/hw_arb_pkg.sv
// Shared types and constants for the two-requester Hamming-weight engine.
// Imported by the top and by the popcount slice.
package hw_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Elaboration-time ceil(log2(value)); returns 0 for value <= 1.
    function automatic int hw_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/slice_popcount.sv
// Combinational population count of one SLICE_WIDTH-bit slice.
// The sum restarts from zero on every evaluation; it holds no state.
module slice_popcount
    import hw_arb_pkg::*;
#(
    parameter int SLICE_WIDTH = 4,
    parameter int COUNT_WIDTH = hw_clog2(SLICE_WIDTH + 1)
) (
    input  logic [SLICE_WIDTH-1:0] slice,
    output logic [COUNT_WIDTH-1:0] count
);

    always_comb begin
        // NOTE: blocking '=' here because each loop step reads the value just
        // written; the zero default also keeps the block free of latches.
        count = '0;
        for (int i = 0; i < SLICE_WIDTH; i++) begin
            count = count + COUNT_WIDTH'(slice[i]);
        end
    end

endmodule

// File: rtl/hamming_weight_arbiter.sv
// Round-robin shared Hamming-weight engine: one popcount slice stepped across
// the granted word, one slice per cycle, result returned over valid/ready.
module hamming_weight_arbiter
    import hw_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int SLICE_WIDTH  = 4,
    parameter int WEIGHT_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0_valid,
    input  logic [DATA_WIDTH-1:0]   req0_data,
    output logic                    req0_ready,
    input  logic                    req1_valid,
    input  logic [DATA_WIDTH-1:0]   req1_data,
    output logic                    req1_ready,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [WEIGHT_WIDTH-1:0] res_weight,
    output logic                    res_parity,
    output logic                    res_id
);

    localparam int NUM_SLICES  = DATA_WIDTH / SLICE_WIDTH;
    localparam int K_WIDTH     = (NUM_SLICES > 1) ? hw_clog2(NUM_SLICES) : 1;
    localparam int COUNT_WIDTH = hw_clog2(SLICE_WIDTH + 1);
    localparam logic [K_WIDTH-1:0] K_LAST = K_WIDTH'(NUM_SLICES - 1);

    state_t                  state;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   word;
    logic                    id;
    logic                    last_grant;
    logic [WEIGHT_WIDTH-1:0] acc;
    logic [K_WIDTH-1:0]      k;
    logic                    any_valid;
    logic                    grant_id;
    logic                    accept;
    logic [SLICE_WIDTH-1:0]  slice;
    logic [COUNT_WIDTH-1:0]  slice_count;

    // On a tie the requester not served last wins.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = REQ1;
        end else begin
            grant_id = REQ0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking '<=' for every register so all state updates
        // see the pre-edge values regardless of statement order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can infer a latch.
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        res_valid  = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                // Gated by reset so the handshake stays closed while held.
                if (!reset && any_valid) begin
                    req0_ready = (grant_id == REQ0);
                    req1_ready = (grant_id == REQ1);
                    accept     = 1'b1;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (k == K_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign res_weight = (state == DONE) ? acc : '0;
    assign res_parity = (state == DONE) ? acc[0] : 1'b0;
    assign res_id     = (state == DONE) ? id : REQ0;

    assign slice = word[k*SLICE_WIDTH +: SLICE_WIDTH];

    slice_popcount #(
        .SLICE_WIDTH (SLICE_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_slice_popcount (
        .slice (slice),
        .count (slice_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id         <= REQ0;
            last_grant <= REQ1;
            acc        <= '0;
            k          <= '0;
        end else if (accept) begin
            id         <= grant_id;
            last_grant <= grant_id;
            acc        <= '0;
            k          <= '0;
        end else if (state == ACCUM) begin
            acc <= acc + WEIGHT_WIDTH'(slice_count);
            if (k != K_LAST) begin
                k <= k + 1'b1;
            end
        end
    end

    // NOTE: the word register carries data only and is always written on
    // accept before use, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            word <= (grant_id == REQ1) ? req1_data : req0_data;
        end
    end

endmodule

// File: tb/tb_hamming_weight_arbiter.sv
// Self-checking bench: a transaction-level model predicts grants, latency and
// results every cycle; directed tests add hand-computed literal expectations.
module tb_hamming_weight_arbiter;

    localparam int DATA_WIDTH   = 32;
    localparam int SLICE_WIDTH  = 4;
    localparam int WEIGHT_WIDTH = 6;
    localparam int NUM_SLICES   = DATA_WIDTH / SLICE_WIDTH;

    logic                    clk;
    logic                    reset;
    logic                    req0_valid;
    logic [DATA_WIDTH-1:0]   req0_data;
    logic                    req0_ready;
    logic                    req1_valid;
    logic [DATA_WIDTH-1:0]   req1_data;
    logic                    req1_ready;
    logic                    res_valid;
    logic                    res_ready;
    logic [WEIGHT_WIDTH-1:0] res_weight;
    logic                    res_parity;
    logic                    res_id;

    int compared   = 0;
    int mismatched = 0;

    hamming_weight_arbiter #(
        .DATA_WIDTH   (DATA_WIDTH),
        .SLICE_WIDTH  (SLICE_WIDTH),
        .WEIGHT_WIDTH (WEIGHT_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_weight (res_weight),
        .res_parity (res_parity),
        .res_id     (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic bound_expired(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s at %0t: wait bound expired", name, $time);
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        int   weight;
        logic parity;
        logic id;
    } result_t;

    result_t m_q[$];
    bit      m_busy   = 1'b0;
    logic    m_last   = 1'b1;
    int      m_accept = 0;
    int      cyc      = 0;

    always @(negedge clk) begin
        logic    e_r0;
        logic    e_r1;
        logic    e_valid;
        result_t r;
        cyc++;
        if (reset) begin
            check("reset req0_ready", 32'(req0_ready), 32'd0);
            check("reset req1_ready", 32'(req1_ready), 32'd0);
            check("reset res_valid",  32'(res_valid),  32'd0);
            check("reset res_weight", 32'(res_weight), 32'd0);
            check("reset res_parity", 32'(res_parity), 32'd0);
            check("reset res_id",     32'(res_id),     32'd0);
            m_busy = 1'b0;
            m_last = 1'b1;
            m_q.delete();
        end else begin
            e_r0 = 1'b0;
            e_r1 = 1'b0;
            if (!m_busy) begin
                if (req0_valid && req1_valid) begin
                    e_r0 = m_last;
                    e_r1 = ~m_last;
                end else begin
                    e_r0 = req0_valid;
                    e_r1 = req1_valid;
                end
            end
            check("model req0_ready", 32'(req0_ready), 32'(e_r0));
            check("model req1_ready", 32'(req1_ready), 32'(e_r1));
            e_valid = m_busy && (cyc >= m_accept + NUM_SLICES + 1);
            check("model res_valid", 32'(res_valid), 32'(e_valid));
            if (e_valid && m_q.size() > 0) begin
                check("model res_weight", 32'(res_weight), 32'(m_q[0].weight));
                check("model res_parity", 32'(res_parity), 32'(m_q[0].parity));
                check("model res_id",     32'(res_id),     32'(m_q[0].id));
            end
            if (e_r0 || e_r1) begin
                r.id     = e_r1;
                r.weight = $countones(e_r1 ? req1_data : req0_data);
                r.parity = ^(e_r1 ? req1_data : req0_data);
                m_q.push_back(r);
                m_busy   = 1'b1;
                m_accept = cyc;
                m_last   = e_r1;
            end else if (e_valid && res_ready) begin
                m_busy = 1'b0;
                void'(m_q.pop_front());
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic which, input logic [DATA_WIDTH-1:0] data);
        bit granted;
        granted = 1'b0;
        if (which) begin
            req1_data  = data;
            req1_valid = 1'b1;
        end else begin
            req0_data  = data;
            req0_valid = 1'b1;
        end
        for (int i = 0; i < 50 && !granted; i++) begin
            @(negedge clk);
            granted = which ? req1_ready : req0_ready;
        end
        if (!granted) bound_expired("send grant");
        @(posedge clk);
        #1;
        if (which) req1_valid = 1'b0;
        else       req0_valid = 1'b0;
    endtask

    task automatic expect_result(input int weight, input logic parity, input logic id, input int latency);
        int  waited;
        bit  seen;
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 100) begin
            @(negedge clk);
            waited++;
            seen = res_valid && res_ready;
        end
        if (!seen) begin
            bound_expired("result wait");
        end else begin
            check("literal weight", 32'(res_weight), 32'(weight));
            check("literal parity", 32'(res_parity), 32'(parity));
            check("literal id",     32'(res_id),     32'(id));
            if (latency > 0) check("literal latency", 32'(waited), 32'(latency));
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        logic [WEIGHT_WIDTH-1:0] held_weight;
        logic                    held_parity;
        logic                    held_id;
        int                      waited;
        int                      stray;

        reset      = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 32'hFFFF_FFFF;
        req1_valid = 1'b0;
        req1_data  = '0;
        res_ready  = 1'b1;

        // All ones from req0, first IDLE cycle after reset.
        repeat (2) @(posedge clk);
        #1 check("ready held low in reset", 32'(req0_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("first idle req0_ready", 32'(req0_ready), 32'd1);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        expect_result(32, 1'b0, 1'b0, NUM_SLICES + 1);

        // req1 alone, several patterns.
        send(1'b1, 32'h0000_0007);
        expect_result(3, 1'b1, 1'b1, NUM_SLICES + 1);
        send(1'b1, 32'h8000_0001);
        expect_result(2, 1'b0, 1'b1, NUM_SLICES + 1);
        send(1'b1, 32'h0000_0000);
        expect_result(0, 1'b0, 1'b1, NUM_SLICES + 1);

        // Both requesters valid continuously: ids alternate, req0 first.
        pulse_reset();
        req0_data  = 32'h0000_00FF;
        req1_data  = 32'h0F0F_0F0F;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        expect_result(8,  1'b0, 1'b0, -1);
        expect_result(16, 1'b0, 1'b1, -1);
        expect_result(8,  1'b0, 1'b0, -1);
        expect_result(16, 1'b0, 1'b1, -1);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Stall in DONE with res_ready low; req1 waits meanwhile.
        @(posedge clk);
        #1 res_ready = 1'b0;
        send(1'b0, 32'h0000_FFFF);
        req1_data  = 32'h0000_0003;
        req1_valid = 1'b1;
        waited = 0;
        while (!res_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!res_valid) bound_expired("stall result wait");
        held_weight = res_weight;
        held_parity = res_parity;
        held_id     = res_id;
        check("stall literal weight", 32'(held_weight), 32'd16);
        check("stall literal id",     32'(held_id),     32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall weight stable", 32'(res_weight), 32'(held_weight));
            check("stall parity stable", 32'(res_parity), 32'(held_parity));
            check("stall id stable",     32'(res_id),     32'(held_id));
            check("stall res_valid",     32'(res_valid),  32'd1);
            check("stall req1_ready",    32'(req1_ready), 32'd0);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        check("idle after pulse res_valid",  32'(res_valid),  32'd0);
        check("idle after pulse req1_ready", 32'(req1_ready), 32'd1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        res_ready  = 1'b1;
        expect_result(2, 1'b0, 1'b1, NUM_SLICES + 1);

        // Reset during ACCUM cycle 3 discards the word.
        send(1'b0, 32'h1234_5678);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("mid reset res_valid",  32'(res_valid),  32'd0);
        check("mid reset res_weight", 32'(res_weight), 32'd0);
        check("mid reset req0_ready", 32'(req0_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (res_valid) stray++;
        end
        check("no stale result", 32'(stray), 32'd0);
        send(1'b1, 32'h0000_00F0);
        expect_result(4, 1'b0, 1'b1, NUM_SLICES + 1);

        // Data changed after accept must not affect the result.
        send(1'b0, 32'hA5A5_A5A5);
        req0_data = 32'hFFFF_FFFF;
        expect_result(16, 1'b0, 1'b0, NUM_SLICES + 1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
